// File: rtl/wash_pkg.sv
// wash_pkg: shared state encoding, mode codes and clear-pulse length for wash_panel
package wash_pkg;
  typedef enum logic [1:0] {SEL, RUN, DONE, CLR} state_t;
  localparam logic [1:0] MODE_SPIN  = 2'b00;
  localparam logic [1:0] MODE_SMALL = 2'b01;
  localparam logic [1:0] MODE_MID   = 2'b10;
  localparam logic [1:0] MODE_LARGE = 2'b11;
  localparam int CLR_CYCLES = 2;
endpackage

// File: rtl/panel_debounce.sv
// panel_debounce: 2-FF synchronizer plus counting debouncer emitting a 1-cycle press on accepted rising levels
module panel_debounce #(
  parameter int DB_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic armed;
  always_ff @(posedge clk) begin
    sync <= {sync[0], raw};
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      armed <= 1'b0;
    end else begin
      press <= 1'b0;
      armed <= armed | ~sync[1];
      if (sync[1] == level) cnt <= '0;
      else if (cnt == CW'(DB_CYCLES - 1)) begin
        cnt   <= '0;
        level <= sync[1];
        press <= sync[1] & armed;
      end else if (cnt != CW'(DB_CYCLES)) cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/wash_panel.sv
// wash_panel: button-driven mode select / start / pause / completion controller for the washer; WASH_PANEL_BEEP_EN builds the buzzer
module wash_panel import wash_pkg::*; #(
  parameter int DB_CYCLES   = 2_000_000,
  parameter int BEEP_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_sel,
  input  logic       btn_go,
  input  logic       btn_pause,
  input  logic       nxt,
  output logic [1:0] mode,
  output logic       m_pos,
  output logic       on,
  output logic       wash_rst_n,
  output logic       done_led,
  output logic       buzzer
);
  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  logic [2:0] lvl;
  logic prs_sel, prs_go, prs_pause;
  logic unused_lvl;
  state_t state, state_n;
  logic [1:0] mode_n;
  logic m_pos_n, on_n, done_n, wrn_n;
  logic [CLR_W-1:0] clr_cnt, clr_n;
  panel_debounce #(.DB_CYCLES(DB_CYCLES)) u_sel (.clk(clk), .rst(rst), .raw(btn_sel), .level(lvl[0]), .press(prs_sel));
  panel_debounce #(.DB_CYCLES(DB_CYCLES)) u_go (.clk(clk), .rst(rst), .raw(btn_go), .level(lvl[1]), .press(prs_go));
  panel_debounce #(.DB_CYCLES(DB_CYCLES)) u_pause (.clk(clk), .rst(rst), .raw(btn_pause), .level(lvl[2]), .press(prs_pause));
  assign unused_lvl = ^lvl;
`ifdef WASH_PANEL_BEEP_EN
  localparam int BW = $clog2(BEEP_CYCLES + 1);
  logic [BW-1:0] beep_cnt, beep_n;
  logic bz_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      beep_cnt <= '0;
      buzzer   <= 1'b0;
    end else begin
      beep_cnt <= beep_n;
      buzzer   <= bz_n;
    end
  end
`else
  assign buzzer = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SEL;
      mode       <= MODE_LARGE;
      m_pos      <= 1'b0;
      on         <= 1'b1;
      done_led   <= 1'b0;
      wash_rst_n <= 1'b0;
      clr_cnt    <= '0;
    end else begin
      state      <= state_n;
      mode       <= mode_n;
      m_pos      <= m_pos_n;
      on         <= on_n;
      done_led   <= done_n;
      wash_rst_n <= wrn_n;
      clr_cnt    <= clr_n;
    end
  end
  always_comb begin
    state_n = state;
    mode_n  = mode;
    m_pos_n = m_pos;
    on_n    = on;
    done_n  = done_led;
    wrn_n   = 1'b1;
    clr_n   = clr_cnt;
`ifdef WASH_PANEL_BEEP_EN
    beep_n  = beep_cnt;
    bz_n    = 1'b0;
`endif
    case (state)
      SEL: begin
        if (prs_go) begin
          state_n = RUN;
          m_pos_n = 1'b1;
        end else if (prs_sel) mode_n = (mode == MODE_LARGE) ? MODE_SPIN : mode + 2'd1;
      end
      RUN: begin
        if (nxt) begin
          state_n = DONE;
          on_n    = 1'b1;
          done_n  = 1'b1;
`ifdef WASH_PANEL_BEEP_EN
          beep_n  = BW'(BEEP_CYCLES);
          bz_n    = 1'b1;
`endif
        end else if (prs_pause) on_n = ~on;
      end
      DONE: begin
`ifdef WASH_PANEL_BEEP_EN
        beep_n = beep_cnt - BW'(beep_cnt != '0);
        bz_n   = (beep_n != '0);
`endif
        if (prs_go) begin
          state_n = CLR;
          m_pos_n = 1'b0;
          done_n  = 1'b0;
          wrn_n   = 1'b0;
          clr_n   = '0;
`ifdef WASH_PANEL_BEEP_EN
          bz_n    = 1'b0;
`endif
        end
      end
      CLR: begin
        if (clr_cnt == CLR_W'(CLR_CYCLES - 1)) state_n = SEL;
        else begin
          clr_n = clr_cnt + 1'b1;
          wrn_n = 1'b0;
        end
      end
      default: state_n = SEL;
    endcase
  end
endmodule

// File: tb/tb_wash_panel.sv
// tb_wash_panel: randomized directed bench for wash_panel against a behavioural panel model
module tb_wash_panel;
  localparam int DB = 4;
  localparam int BEEP = 10;
`ifdef WASH_PANEL_BEEP_EN
  localparam int EXP_BEEP = BEEP;
`else
  localparam int EXP_BEEP = 0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_sel = 1'b0, btn_go = 1'b0, btn_pause = 1'b0, nxt = 1'b0;
  logic [1:0] mode;
  logic m_pos, on, wash_rst_n, done_led, buzzer;
  int vectors = 0;
  int miscompares = 0;
  int wlow = 0;
  int bz_cnt = 0;
  logic [2:0] snap = 3'b111;
  int exp_mode;
  logic exp_on;
  wash_panel #(.DB_CYCLES(DB), .BEEP_CYCLES(BEEP)) dut (
    .clk(clk), .rst(rst), .btn_sel(btn_sel), .btn_go(btn_go), .btn_pause(btn_pause),
    .nxt(nxt), .mode(mode), .m_pos(m_pos), .on(on), .wash_rst_n(wash_rst_n),
    .done_led(done_led), .buzzer(buzzer)
  );
  always #5 clk = ~clk;
  // one negedge step; also plays the washer, whose nxt flag clears while it is held in reset
  task automatic tick();
    @(negedge clk);
    bz_cnt += int'(buzzer);
    if (!wash_rst_n) begin
      wlow++;
      if (wlow == 1) snap = {m_pos, done_led, buzzer};
      nxt = 1'b0;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic press(input logic s, input logic g, input logic p);
    int h;
    h = $urandom_range(DB + 5, DB + 1);
    btn_sel = s;
    btn_go = g;
    btn_pause = p;
    repeat (h) tick();
    btn_sel = 1'b0;
    btn_go = 1'b0;
    btn_pause = 1'b0;
    repeat (DB + 6) tick();
  endtask
  initial begin
    int n;
    repeat (3) tick();
    chk("rst_mode", mode, 3);
    chk("rst_m_pos", m_pos, 0);
    chk("rst_on", on, 1);
    chk("rst_done", done_led, 0);
    chk("rst_buzzer", buzzer, 0);
    chk("rst_wrn", wash_rst_n, 0);
    rst = 1'b0;
    tick();
    chk("wrn_after_rst", wash_rst_n, 1);
    exp_mode = 3;
    exp_on = 1'b1;
    repeat (2) begin
      btn_sel = 1'b1;
      repeat ($urandom_range(DB - 1, 1)) tick();
      btn_sel = 1'b0;
      repeat (DB + 6) tick();
      chk("glitch_mode", mode, exp_mode);
    end
    for (int i = 0; i < 3; i++) begin
      press(1, 0, 0);
      exp_mode = (exp_mode + 1) % 4;
      chk("sel_step", mode, exp_mode);
    end
    n = $urandom_range(7, 0);
    for (int i = 0; i < n; i++) begin
      press(1, 0, 0);
      exp_mode = (exp_mode + 1) % 4;
      chk("sel_rand", mode, exp_mode);
    end
    while (exp_mode != 1) begin
      press(1, 0, 0);
      exp_mode = (exp_mode + 1) % 4;
      chk("sel_to_small", mode, exp_mode);
    end
    press(1, 1, 0);
    chk("coinc_m_pos", m_pos, 1);
    chk("coinc_mode", mode, 1);
    chk("coinc_done", done_led, 0);
    for (int i = 0; i < 2; i++) begin
      press(0, 0, 1);
      exp_on = ~exp_on;
      chk("pause_on", on, exp_on);
    end
    n = $urandom_range(3, 1);
    for (int i = 0; i < n; i++) begin
      press(1, 0, 0);
      chk("run_sel_mode", mode, exp_mode);
      chk("run_m_pos", m_pos, 1);
    end
    press(0, 1, 0);
    chk("run_go_m_pos", m_pos, 1);
    chk("run_go_done", done_led, 0);
    press(0, 0, 1);
    chk("pause_off", on, 0);
    chk("pre_nxt_done", done_led, 0);
    bz_cnt = 0;
    nxt = 1'b1;
    tick();
    chk("nxt_done", done_led, 1);
    chk("nxt_buzzer", buzzer, EXP_BEEP != 0);
    chk("nxt_on_forced", on, 1);
    chk("nxt_m_pos", m_pos, 1);
    repeat (BEEP + 9) tick();
    chk("beep_len", bz_cnt, EXP_BEEP);
    chk("beep_end", buzzer, 0);
    chk("done_hold", done_led, 1);
    press(1, 0, 1);
    chk("done_sel_mode", mode, exp_mode);
    chk("done_pause_on", on, 1);
    chk("done_ignored", done_led, 1);
    wlow = 0;
    press(0, 1, 0);
    chk("clr_low_len", wlow, 2);
    chk("clr_snapshot", snap, 0);
    chk("clr_wrn_back", wash_rst_n, 1);
    chk("clr_m_pos", m_pos, 0);
    chk("clr_mode", mode, exp_mode);
    chk("clr_done", done_led, 0);
    press(1, 0, 0);
    exp_mode = (exp_mode + 1) % 4;
    chk("sel_after_clr", mode, exp_mode);
    press(0, 1, 0);
    chk("rerun_m_pos", m_pos, 1);
    press(0, 0, 1);
    chk("rerun_pause", on, 0);
    rst = 1'b1;
    tick();
    chk("midrun_mode", mode, 3);
    chk("midrun_m_pos", m_pos, 0);
    chk("midrun_on", on, 1);
    chk("midrun_done", done_led, 0);
    chk("midrun_buzzer", buzzer, 0);
    chk("midrun_wrn", wash_rst_n, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("midrun_release", wash_rst_n, 1);
    exp_mode = 3;
    btn_sel = 1'b1;
    repeat (10) tick();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (15) tick();
    chk("held_across_rst", mode, exp_mode);
    btn_sel = 1'b0;
    repeat (DB + 6) tick();
    chk("held_release", mode, exp_mode);
    press(1, 0, 0);
    exp_mode = (exp_mode + 1) % 4;
    chk("held_repress", mode, exp_mode);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
